mips_io_responder: RTL and testbench

- Memory-mapped I/O responder on the 8-bit multicycle MIPS memory bus. It sits beside the RAM inside mips_mem and owns the top four addresses.
- CPU stores to the data port are queued in a small FIFO and drained to an external consumer over a valid/ready handshake.
- Status, last-written byte and write count are readable by CPU loads, so software can poll instead of relying on a bench snooping the bus.

---
 rtl/mips_io_responder_pkg.sv | 23 ++
 rtl/mips_io_responder_if.sv | 23 ++
 rtl/mips_io_responder_fifo.sv | 72 +++++++
 rtl/mips_io_responder.sv | 96 +++++++++
 tb/tb_mips_io_responder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mips_io_responder_pkg.sv
// Shared constants for the MIPS memory-mapped I/O responder.
// Holds the register offsets, the status bit positions and a constant-safe clog2.
package mips_io_pkg;

  localparam logic [1:0] IO_OFF_CLR  = 2'd0;
  localparam logic [1:0] IO_OFF_LAST = 2'd1;
  localparam logic [1:0] IO_OFF_STAT = 2'd2;
  localparam logic [1:0] IO_OFF_DATA = 2'd3;

  localparam int ST_OVF   = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_EMPTY = 5;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_io_responder_if.sv
// CPU bus plus consumer stream of the I/O responder.
// The master side is the CPU/consumer; the slave side is the responder.
interface mips_io_responder_if #(parameter int WIDTH = 8);
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic             io_sel;
  logic [WIDTH-1:0] io_rdata;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  modport master (
    output memwrite, adr, writedata, out_ready,
    input  io_sel, io_rdata, out_data, out_valid, overflow
  );

  modport slave (
    input  memwrite, adr, writedata, out_ready,
    output io_sel, io_rdata, out_data, out_valid, overflow
  );
endinterface

// File: rtl/mips_io_responder_fifo.sv
// Small synchronous byte FIFO with flush; head reads 0 while empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module io_byte_fifo
  import mips_io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [WIDTH-1:0]        data_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]        head_o
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mips_io_responder.sv
// Memory-mapped I/O responder owning BASE..BASE+3 on the 8-bit MIPS bus.
// Decodes CPU stores/loads, queues data-port stores and tracks last byte, count and overflow.
module mips_io_responder
  import mips_io_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] BASE  = 8'hFC
) (
  input logic                 clk,
  input logic                 reset,
  mips_io_responder_if.slave  bus_if
);
  localparam int CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] last_wr_q, last_wr_d;
  logic [WIDTH-1:0] wr_count_q, wr_count_d;
  logic             overflow_q, overflow_d;
  logic [1:0]       offset;
  logic             wr_en, clr, push, pop, full, empty;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic [7:0]       status;

  assign bus_if.io_sel = (bus_if.adr[WIDTH-1:2] == BASE[WIDTH-1:2]);
  assign offset        = bus_if.adr[1:0];
  assign wr_en         = bus_if.memwrite && bus_if.io_sel;
  assign clr           = wr_en && (offset == IO_OFF_CLR);
  assign push          = wr_en && (offset == IO_OFF_DATA);
  assign pop           = !empty && bus_if.out_ready;

  io_byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (clr),
    .data_i  (bus_if.writedata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

  assign bus_if.out_data  = head;
  assign bus_if.out_valid = !empty;
  assign bus_if.overflow  = overflow_q;

  always_comb begin
    status           = '0;
    status[ST_OVF]   = overflow_q;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[3:0]      = 4'(count);
  end

  always_comb begin
    bus_if.io_rdata = '0;
    if (bus_if.io_sel) begin
      case (offset)
        IO_OFF_CLR:  bus_if.io_rdata = wr_count_q;
        IO_OFF_LAST: bus_if.io_rdata = last_wr_q;
        IO_OFF_STAT: bus_if.io_rdata = WIDTH'(status);
        default:     bus_if.io_rdata = head;
      endcase
    end
  end

  // Dropped bytes still update last_wr and wr_count so software sees every store.
  always_comb begin
    last_wr_d  = last_wr_q;
    wr_count_d = wr_count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_count_d = '0;
      overflow_d = 1'b0;
    end else if (push) begin
      last_wr_d  = bus_if.writedata;
      wr_count_d = wr_count_q + WIDTH'(1);
      if (full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_wr_q  <= '0;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      last_wr_q  <= last_wr_d;
      wr_count_q <= wr_count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mips_io_responder.sv
// Directed bench for mips_io_responder with hand-computed expected values.
module tb_mips_io_responder;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mips_io_responder_if #(.WIDTH(8)) bus ();

  mips_io_responder #(.WIDTH(8), .DEPTH(4), .BASE(8'hFC)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    bus.memwrite  = 1'b1;
    bus.adr       = a;
    bus.writedata = d;
    tick();
    bus.memwrite  = 1'b0;
    bus.adr       = 8'h00;
  endtask

  task automatic check_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.adr = a;
    #1;
    check(tag, bus.io_rdata, exp);
    bus.adr = 8'h00;
  endtask

  task automatic drain(input string tag, input logic [7:0] exp);
    check(tag, {bus.out_valid, bus.out_data}, {1'b1, exp});
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset         = 1'b0;
    bus.memwrite  = 1'b0;
    bus.adr       = 8'h00;
    bus.writedata = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (4) tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_data", bus.out_data, 0);
    check_rd("rst_stat", 8'hFE, 8'h20);
    check_rd("rst_cnt", 8'hFC, 8'h00);
    reset = 1'b1;
    tick();

    // First push, popped the cycle after it becomes visible
    bus.out_ready = 1'b1;
    store(8'hFF, 8'h0D);
    check("p1_valid", bus.out_valid, 1);
    check("p1_data", bus.out_data, 8'h0D);
    tick();
    check("p1_gone", bus.out_valid, 0);
    check_rd("p1_last", 8'hFD, 8'h0D);
    check_rd("p1_cnt", 8'hFC, 8'h01);

    // Fill and overflow
    bus.out_ready = 1'b0;
    store(8'hFC, 8'h00);
    check_rd("clr_cnt", 8'hFC, 8'h00);
    for (int i = 1; i <= 4; i++) store(8'hFF, 8'(i));
    check_rd("full_stat", 8'hFE, 8'h44);
    check_rd("full_head", 8'hFF, 8'h01);
    store(8'hFF, 8'h05);
    check_rd("ovf_stat", 8'hFE, 8'hC4);
    check("ovf_flag", bus.overflow, 1);
    check_rd("ovf_last", 8'hFD, 8'h05);
    check_rd("ovf_cnt", 8'hFC, 8'h05);
    bus.out_ready = 1'b1;
    drain("ovf_d1", 8'h01);
    drain("ovf_d2", 8'h02);
    drain("ovf_d3", 8'h03);
    drain("ovf_d4", 8'h04);
    check("ovf_empty", bus.out_valid, 0);
    check_rd("ovf_head0", 8'hFF, 8'h00);

    // Full with simultaneous pop
    bus.out_ready = 1'b0;
    store(8'hFC, 8'h00);
    check("fp_ovf_clr", bus.overflow, 0);
    for (int i = 1; i <= 4; i++) store(8'hFF, 8'(i));
    bus.out_ready = 1'b1;
    store(8'hFF, 8'h09);
    bus.out_ready = 1'b0;
    check("fp_ovf", bus.overflow, 0);
    check_rd("fp_stat", 8'hFE, 8'h44);
    bus.out_ready = 1'b1;
    drain("fp_d1", 8'h02);
    drain("fp_d2", 8'h03);
    drain("fp_d3", 8'h04);
    drain("fp_d4", 8'h09);
    check("fp_empty", bus.out_valid, 0);

    // Backpressure hold
    bus.out_ready = 1'b0;
    store(8'hFF, 8'hAA);
    store(8'hFF, 8'hBB);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {bus.out_valid, bus.out_data}, {1'b1, 8'hAA});
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_next", {bus.out_valid, bus.out_data}, {1'b1, 8'hBB});
    check_rd("bp_stat", 8'hFE, 8'h01);

    // Clear with a pending pop: clear wins, nothing delivered
    store(8'hFC, 8'h00);
    for (int i = 1; i <= 5; i++) store(8'hFF, 8'(i));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_rd("cl_pre_stat", 8'hFE, 8'h83);
    bus.out_ready = 1'b1;
    store(8'hFC, 8'h77);
    bus.out_ready = 1'b0;
    check("cl_valid", bus.out_valid, 0);
    check("cl_data", bus.out_data, 0);
    check_rd("cl_stat", 8'hFE, 8'h20);
    check("cl_ovf", bus.overflow, 0);
    check_rd("cl_cnt", 8'hFC, 8'h00);
    check_rd("cl_last", 8'hFD, 8'h05);

    // Decode: read-only and out-of-range stores change nothing
    store(8'hFE, 8'h55);
    store(8'hFD, 8'h56);
    bus.adr = 8'hFB;
    #1;
    check("dec_sel_fb", bus.io_sel, 0);
    check("dec_rd_fb", bus.io_rdata, 0);
    bus.adr = 8'hFC;
    #1;
    check("dec_sel_fc", bus.io_sel, 1);
    store(8'hFB, 8'h66);
    check_rd("dec_stat", 8'hFE, 8'h20);
    check_rd("dec_cnt", 8'hFC, 8'h00);
    check_rd("dec_last", 8'hFD, 8'h05);

    // Reset mid-operation
    store(8'hFF, 8'h11);
    store(8'hFF, 8'h22);
    check_rd("mr_pre_stat", 8'hFE, 8'h02);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mr_valid", bus.out_valid, 0);
    check_rd("mr_stat", 8'hFE, 8'h20);
    check_rd("mr_last", 8'hFD, 8'h00);
    check_rd("mr_cnt", 8'hFC, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
